// File: rtl/sweep_pkg.sv
// Shared types and constants for the frequency-sweep sequencer.
package sweep_pkg;

  localparam int RES_WIDTH_DEF    = 32;
  localparam int AVG_MAX_LOG2_DEF = 7;
  localparam int ACC_WIDTH        = RES_WIDTH_DEF + AVG_MAX_LOG2_DEF;
  localparam int TIMEOUT_DEF      = 2**20;

  // Sequencer states; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TRIG   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Accumulator width for a given result width and maximum averaging depth:
  // 2^avg_max sums of res_w-bit words never overflow this.
  function automatic int acc_width(input int res_w, input int avg_max);
    return res_w + avg_max;
  endfunction

endpackage

// File: rtl/sweep_scheduler_if.sv
// Measurement-engine trigger/reply and averaged-result stream of the sweep sequencer.
interface sweep_scheduler_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int RES_WIDTH  = 32
);
  logic                         freq_addr_unused_guard;
  logic [ADDR_WIDTH-1:0]        freq_addr;
  logic                         meas_start;
  logic                         meas_done;
  logic signed [RES_WIDTH-1:0]  meas_modulo;
  logic signed [RES_WIDTH-1:0]  meas_phase;
  logic                         res_valid;
  logic                         res_ready;
  logic [ADDR_WIDTH-1:0]        res_addr;
  logic signed [RES_WIDTH-1:0]  res_modulo;
  logic signed [RES_WIDTH-1:0]  res_phase;

  // Sequencer side: drives the ROM address, the trigger and the result stream.
  modport master (
    output freq_addr, meas_start,
    input  meas_done, meas_modulo, meas_phase,
    output res_valid, res_addr, res_modulo, res_phase,
    input  res_ready
  );

  // Engine / consumer side.
  modport slave (
    input  freq_addr, meas_start,
    output meas_done, meas_modulo, meas_phase,
    input  res_valid, res_addr, res_modulo, res_phase,
    output res_ready
  );
endinterface

// File: rtl/sweep_accum.sv
// Pair of signed accumulators (modulus, phase) with clear, add-enable and an
// averaged output that already includes the word being added this cycle, so
// the final average can be registered on the same edge as the last add.
module sweep_accum
  import sweep_pkg::*;
#(
  parameter int RES_WIDTH    = 32,
  parameter int AVG_MAX_LOG2 = 7
) (
  input  logic                        clk125,
  input  logic                        areset_n,
  input  logic                        clear,
  input  logic                        add_en,
  input  logic signed [RES_WIDTH-1:0] in_modulo,
  input  logic signed [RES_WIDTH-1:0] in_phase,
  input  logic [2:0]                  shift,
  output logic signed [RES_WIDTH-1:0] avg_modulo,
  output logic signed [RES_WIDTH-1:0] avg_phase
);

  localparam int AW = acc_width(RES_WIDTH, AVG_MAX_LOG2);

  logic signed [AW-1:0] acc_mod_reg;
  logic signed [AW-1:0] acc_ph_reg;
  logic signed [AW-1:0] sum_mod;
  logic signed [AW-1:0] sum_ph;

  assign sum_mod = acc_mod_reg + {{AVG_MAX_LOG2{in_modulo[RES_WIDTH-1]}}, in_modulo};
  assign sum_ph  = acc_ph_reg  + {{AVG_MAX_LOG2{in_phase[RES_WIDTH-1]}}, in_phase};

  // Arithmetic shift floors toward -inf; the average always fits RES_WIDTH.
  assign avg_modulo = RES_WIDTH'(sum_mod >>> shift);
  assign avg_phase  = RES_WIDTH'(sum_ph >>> shift);

  // Accumulator registers: clear has priority over add.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      acc_mod_reg <= '0;
      acc_ph_reg  <= '0;
    end else if (clear) begin
      acc_mod_reg <= '0;
      acc_ph_reg  <= '0;
    end else if (add_en) begin
      acc_mod_reg <= sum_mod;
      acc_ph_reg  <= sum_ph;
    end
  end

endmodule

// File: rtl/sweep_scheduler.sv
// Frequency-sweep sequencer: walks ROM addresses first..last, settles, fires
// 2^avg_log2 measurements per point and streams one averaged result per point.
module sweep_scheduler
  import sweep_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int RES_WIDTH    = 32,
  parameter int AVG_MAX_LOG2 = 7,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                  clk125,
  input  logic                  areset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [2:0]            avg_log2,
  input  logic [15:0]           settle_cycles,
  sweep_scheduler_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = AVG_MAX_LOG2 + 1;

  state_t state_reg, state_next;

  logic                        start_q_reg, start_q2_reg, start_rise;
  logic [ADDR_WIDTH-1:0]       freq_addr_reg, freq_addr_next;
  logic [ADDR_WIDTH-1:0]       last_cfg_reg, last_cfg_next;
  logic [2:0]                  avg_cfg_reg, avg_cfg_next, avg_clamped;
  logic [15:0]                 settle_cfg_reg, settle_cfg_next;
  logic [15:0]                 settle_cnt_reg, settle_cnt_next;
  logic [TW-1:0]               tmo_cnt_reg, tmo_cnt_next;
  logic [CW-1:0]               avg_cnt_reg, avg_cnt_next, avg_last;
  logic [ADDR_WIDTH-1:0]       res_addr_reg, res_addr_next;
  logic signed [RES_WIDTH-1:0] res_mod_reg, res_mod_next;
  logic signed [RES_WIDTH-1:0] res_ph_reg, res_ph_next;
  logic                        error_reg, error_next;
  logic                        acc_clear, acc_add;
  logic signed [RES_WIDTH-1:0] avg_modulo, avg_phase;

  assign start_rise  = start_q_reg & ~start_q2_reg;
  assign avg_clamped = (int'(avg_log2) > AVG_MAX_LOG2) ? 3'(AVG_MAX_LOG2) : avg_log2;
  assign avg_last    = (CW'(1) << avg_cfg_reg) - CW'(1);

  sweep_accum #(
    .RES_WIDTH    (RES_WIDTH),
    .AVG_MAX_LOG2 (AVG_MAX_LOG2)
  ) u_accum (
    .clk125     (clk125),
    .areset_n   (areset_n),
    .clear      (acc_clear),
    .add_en     (acc_add),
    .in_modulo  (bus.meas_modulo),
    .in_phase   (bus.meas_phase),
    .shift      (avg_cfg_reg),
    .avg_modulo (avg_modulo),
    .avg_phase  (avg_phase)
  );

  // State register.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  // Next-state, counters and result capture; abort overrides every state.
  always_comb begin
    state_next      = state_reg;
    freq_addr_next  = freq_addr_reg;
    last_cfg_next   = last_cfg_reg;
    avg_cfg_next    = avg_cfg_reg;
    settle_cfg_next = settle_cfg_reg;
    settle_cnt_next = settle_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    avg_cnt_next    = avg_cnt_reg;
    res_addr_next   = res_addr_reg;
    res_mod_next    = res_mod_reg;
    res_ph_next     = res_ph_reg;
    error_next      = error_reg;
    acc_clear       = 1'b0;
    acc_add         = 1'b0;
    if (abort) begin
      state_next   = ST_IDLE;
      acc_clear    = 1'b1;
      avg_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_rise) begin
            freq_addr_next  = first_addr;
            last_cfg_next   = last_addr;
            avg_cfg_next    = avg_clamped;
            settle_cfg_next = settle_cycles;
            settle_cnt_next = settle_cycles;
            avg_cnt_next    = '0;
            acc_clear       = 1'b1;
            error_next      = 1'b0;
            state_next      = (first_addr > last_addr) ? ST_DONE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == 16'd0) state_next = ST_TRIG;
          else                         settle_cnt_next = settle_cnt_reg - 16'd1;
        end
        ST_TRIG: begin
          tmo_cnt_next = '0;
          state_next   = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.meas_done) begin
            acc_add      = 1'b1;
            avg_cnt_next = avg_cnt_reg + CW'(1);
            if (avg_cnt_reg == avg_last) begin
              res_mod_next  = avg_modulo;
              res_ph_next   = avg_phase;
              res_addr_next = freq_addr_reg;
              state_next    = ST_EMIT;
            end else begin
              state_next = ST_TRIG;
            end
          end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
            error_next = 1'b1;
            state_next = ST_DONE;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + TW'(1);
          end
        end
        ST_EMIT: begin
          if (bus.res_ready) begin
            // Compare before incrementing so last==all-ones never wraps.
            if (freq_addr_reg == last_cfg_reg) begin
              state_next = ST_DONE;
            end else begin
              freq_addr_next  = freq_addr_reg + ADDR_WIDTH'(1);
              acc_clear       = 1'b1;
              avg_cnt_next    = '0;
              settle_cnt_next = settle_cfg_reg;
              state_next      = ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          if (!start) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath registers and the two-stage start edge detector.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      start_q_reg    <= 1'b0;
      start_q2_reg   <= 1'b0;
      freq_addr_reg  <= '0;
      last_cfg_reg   <= '0;
      avg_cfg_reg    <= '0;
      settle_cfg_reg <= '0;
      settle_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      avg_cnt_reg    <= '0;
      res_addr_reg   <= '0;
      res_mod_reg    <= '0;
      res_ph_reg     <= '0;
      error_reg      <= 1'b0;
    end else begin
      start_q_reg    <= start;
      start_q2_reg   <= start_q_reg;
      freq_addr_reg  <= freq_addr_next;
      last_cfg_reg   <= last_cfg_next;
      avg_cfg_reg    <= avg_cfg_next;
      settle_cfg_reg <= settle_cfg_next;
      settle_cnt_reg <= settle_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      avg_cnt_reg    <= avg_cnt_next;
      res_addr_reg   <= res_addr_next;
      res_mod_reg    <= res_mod_next;
      res_ph_reg     <= res_ph_next;
      error_reg      <= error_next;
    end
  end

  assign bus.freq_addr  = freq_addr_reg;
  assign bus.meas_start = (state_reg == ST_TRIG);
  assign bus.res_valid  = (state_reg == ST_EMIT);
  assign bus.res_addr   = res_addr_reg;
  assign bus.res_modulo = res_mod_reg;
  assign bus.res_phase  = res_ph_reg;
  assign busy           = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done           = (state_reg == ST_DONE);
  assign error          = error_reg;
  assign state_dbg      = state_reg;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Self-checking bench for sweep_scheduler: engine responder, ready driver,
// stream monitor against a per-point average model, and directed/random sweeps.
module tb_sweep_scheduler;
  import sweep_pkg::*;

  localparam int AW  = 8;
  localparam int RW  = 32;
  localparam int TMO = 64;

  logic          clk125 = 1'b0;
  logic          areset_n;
  logic          start, abort;
  logic [AW-1:0] first_addr, last_addr;
  logic [2:0]    avg_log2;
  logic [15:0]   settle_cycles;
  logic          busy, done, error;
  logic [2:0]    state_dbg;

  sweep_scheduler_if #(.ADDR_WIDTH(AW), .RES_WIDTH(RW)) bus();

  sweep_scheduler #(
    .ADDR_WIDTH(AW), .RES_WIDTH(RW), .AVG_MAX_LOG2(7), .TIMEOUT(TMO)
  ) dut (
    .clk125(clk125), .areset_n(areset_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr), .avg_log2(avg_log2),
    .settle_cycles(settle_cycles), .bus(bus), .busy(busy), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  always #4 clk125 = ~clk125;

  typedef struct { int addr; longint modulo; longint phase; } result_t;

  result_t exp_q[$];
  int      mod_q[$];
  int      ph_q[$];
  int      settle_runs[$];
  int      checks = 0;
  int      errors = 0;
  int      n_starts = 0;
  int      n_results = 0;
  int      settle_run = 0;
  bit      eng_mute = 0;
  bit      eng_lat_rand = 0;
  int      eng_lat = 10;
  int      ready_mode = 0;

  task automatic check(input string tag, input longint obs, input longint exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Model: queue engine replies and the expected per-point average.
  // mode 0 random, 1 constant 100/-8, 2 fixed four-entry table.
  task automatic plan_sweep(input int f, input int l, input int a, input int mode);
    int tm[4] = '{10, 11, 12, 14};
    int tp[4] = '{-1, -2, -2, -2};
    for (int adr = f; adr <= l; adr++) begin
      longint sm = 0, sp = 0;
      int n = 1 << a;
      for (int k = 0; k < n; k++) begin
        int m, p;
        if (mode == 1) begin m = 100; p = -8; end
        else if (mode == 2) begin m = tm[k % 4]; p = tp[k % 4]; end
        else if ($urandom_range(0, 9) == 0) begin m = int'($urandom); p = int'($urandom); end
        else begin m = int'($urandom_range(0, 2000)) - 1000; p = int'($urandom_range(0, 2000)) - 1000; end
        mod_q.push_back(m);
        ph_q.push_back(p);
        sm += m;
        sp += p;
      end
      exp_q.push_back('{adr, floor_div(sm, n), floor_div(sp, n)});
    end
  endtask

  task automatic launch(input int f, input int l, input int a, input int s, input bit scramble);
    first_addr    = AW'(f);
    last_addr     = AW'(l);
    avg_log2      = 3'(a);
    settle_cycles = 16'(s);
    start         = 1'b1;
    for (int i = 0; i < 8 && state_dbg == ST_IDLE; i++) @(negedge clk125);
    if (scramble) begin
      first_addr    = AW'($urandom);
      last_addr     = AW'($urandom);
      avg_log2      = 3'($urandom);
      settle_cycles = 16'($urandom);
    end
  endtask

  task automatic finish_sweep(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk125); n++; end
    check({tag, "_done"}, done, 1);
    start = 1'b0;
    @(negedge clk125);
    @(negedge clk125);
    check({tag, "_idle"}, state_dbg, ST_IDLE);
  endtask

  task automatic wait_trig(input string tag);
    int n = 0;
    while (bus.meas_start !== 1'b1 && n < 200) begin @(negedge clk125); n++; end
    check({tag, "_trig_seen"}, bus.meas_start, 1);
  endtask

  // Measurement engine: replies eng_lat cycles after each trigger.
  initial begin
    int lat;
    bus.meas_done   = 1'b0;
    bus.meas_modulo = '0;
    bus.meas_phase  = '0;
    forever begin
      @(negedge clk125);
      bus.meas_done = 1'b0;
      if (bus.meas_start === 1'b1 && !eng_mute) begin
        lat = eng_lat_rand ? int'($urandom_range(1, 6)) : eng_lat;
        repeat (lat) @(negedge clk125);
        bus.meas_modulo = (mod_q.size() > 0) ? mod_q.pop_front() : int'($urandom);
        bus.meas_phase  = (ph_q.size() > 0)  ? ph_q.pop_front()  : int'($urandom);
        bus.meas_done   = 1'b1;
      end
    end
  end

  // Downstream ready: 0 always ready, 1 random, otherwise held low.
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk125);
      #1;
      case (ready_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor: settle lengths, trigger address, accepted results.
  initial begin
    result_t r;
    forever begin
      @(negedge clk125);
      if (areset_n === 1'b1) begin
        if (state_dbg == ST_IDLE) settle_run = 0;
        if (state_dbg == ST_SETTLE) settle_run++;
        if (bus.meas_start === 1'b1) begin
          n_starts++;
          if (settle_run > 0) begin settle_runs.push_back(settle_run); settle_run = 0; end
          if (exp_q.size() > 0) check("trig_addr", bus.freq_addr, exp_q[0].addr);
        end
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
          n_results++;
          if (exp_q.size() == 0) check("res_unexpected", bus.res_addr, -1);
          else begin
            r = exp_q.pop_front();
            check("res_addr", bus.res_addr, r.addr);
            check("res_modulo", bus.res_modulo, r.modulo);
            check("res_phase", bus.res_phase, r.phase);
          end
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, wc, n, a;
    longint snap_mod, snap_ph, snap_addr, snap_freq;
    start = 0; abort = 0; first_addr = 0; last_addr = 0; avg_log2 = 0; settle_cycles = 0;
    areset_n = 1'b0;
    repeat (3) @(negedge clk125);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_freq_addr", bus.freq_addr, 0);
    check("rst_meas_start", bus.meas_start, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_addr", bus.res_addr, 0);
    check("rst_res_modulo", bus.res_modulo, 0);
    check("rst_res_phase", bus.res_phase, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    areset_n = 1'b1;
    @(negedge clk125);

    // Three points, constant engine reply, 4-cycle settle.
    settle_runs.delete(); r0 = n_results;
    plan_sweep(3, 5, 0, 1);
    launch(3, 5, 0, 4, 0);
    finish_sweep("t1", 2000);
    check("t1_results", n_results - r0, 3);
    check("t1_pending", exp_q.size(), 0);
    check("t1_settle_runs", settle_runs.size(), 3);
    foreach (settle_runs[i]) check("t1_settle_len", settle_runs[i], 5);
    check("t1_error", error, 0);

    // Four-measurement average with floor rounding.
    s0 = n_starts;
    plan_sweep(7, 7, 2, 2);
    launch(7, 7, 2, 0, 0);
    finish_sweep("t2", 2000);
    check("t2_triggers", n_starts - s0, 4);
    check("t2_pending", exp_q.size(), 0);

    // Backpressure: ready low for 20 cycles in EMIT.
    ready_mode = 2;
    plan_sweep(10, 11, 1, 0);
    launch(10, 11, 1, 2, 1);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 500) begin @(negedge clk125); n++; end
    check("t3_valid_seen", bus.res_valid, 1);
    snap_mod = bus.res_modulo; snap_ph = bus.res_phase; snap_addr = bus.res_addr;
    snap_freq = bus.freq_addr; s0 = n_starts; wc = 0;
    repeat (20) begin
      @(negedge clk125);
      if (bus.res_valid === 1'b1 && bus.res_modulo == snap_mod && bus.res_phase == snap_ph &&
          bus.res_addr == snap_addr && bus.freq_addr == snap_freq) wc++;
    end
    check("t3_held_cycles", wc, 20);
    check("t3_no_trigger", n_starts - s0, 0);
    ready_mode = 0;
    finish_sweep("t3", 2000);
    check("t3_pending", exp_q.size(), 0);

    // Silent engine: timeout after TMO cycles in WAIT, sticky error.
    eng_mute = 1;
    launch(0, 3, 0, 1, 0);
    wait_trig("t4");
    @(negedge clk125);
    wc = 0;
    while (state_dbg == ST_WAIT && wc < 500) begin wc++; @(negedge clk125); end
    check("t4_wait_cycles", wc, TMO);
    check("t4_state", state_dbg, ST_DONE);
    check("t4_error", error, 1);
    check("t4_done", done, 1);
    start = 1'b0;
    repeat (3) @(negedge clk125);
    check("t4_idle", state_dbg, ST_IDLE);
    check("t4_error_sticky", error, 1);
    eng_mute = 0;
    plan_sweep(1, 1, 0, 0);
    launch(1, 1, 0, 0, 0);
    check("t4_error_cleared", error, 0);
    finish_sweep("t4b", 2000);
    check("t4_pending", exp_q.size(), 0);

    // Abort in WAIT with a late engine reply, then relaunch.
    eng_lat = 30;
    plan_sweep(2, 4, 0, 0);
    launch(2, 4, 0, 0, 0);
    wait_trig("t5");
    repeat (5) @(negedge clk125);
    abort = 1'b1;
    @(negedge clk125);
    check("t5_state", state_dbg, ST_IDLE);
    check("t5_res_valid", bus.res_valid, 0);
    check("t5_done", done, 0);
    check("t5_busy", busy, 0);
    check("t5_error", error, 0);
    abort = 1'b0; start = 1'b0;
    exp_q.delete(); mod_q.delete(); ph_q.delete();
    r0 = n_results;
    repeat (40) @(negedge clk125);
    check("t5_still_idle", state_dbg, ST_IDLE);
    check("t5_no_result", n_results - r0, 0);
    eng_lat = 10;
    a = int'($urandom_range(0, 3));
    plan_sweep(0, 0, a, 0);
    launch(0, 0, a, 3, 0);
    finish_sweep("t5b", 2000);
    check("t5_relaunch_results", n_results - r0, 1);
    check("t5_pending", exp_q.size(), 0);

    // Empty range, start held high does not relaunch.
    s0 = n_starts; r0 = n_results;
    launch(9, 2, 1, 1, 0);
    repeat (20) @(negedge clk125);
    check("t6_state", state_dbg, ST_DONE);
    check("t6_done", done, 1);
    check("t6_no_trigger", n_starts - s0, 0);
    check("t6_no_result", n_results - r0, 0);
    start = 1'b0;
    repeat (2) @(negedge clk125);
    check("t6_idle", state_dbg, ST_IDLE);
    check("t6_done_low", done, 0);

    // Top of the address space terminates without wrapping.
    plan_sweep(254, 255, 1, 0);
    launch(254, 255, 1, 1, 0);
    finish_sweep("t7", 2000);
    check("t7_freq_addr", bus.freq_addr, 255);
    check("t7_pending", exp_q.size(), 0);

    // Random sweeps with random latency, backpressure and config churn.
    eng_lat_rand = 1;
    ready_mode = 1;
    for (int it = 0; it < 6; it++) begin
      int f, l, av, st;
      f  = int'($urandom_range(0, 250));
      l  = f + int'($urandom_range(0, 3));
      av = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 5));
      settle_runs.delete(); s0 = n_starts;
      plan_sweep(f, l, av, 0);
      launch(f, l, av, st, 1);
      finish_sweep("rnd", 5000);
      check("rnd_pending", exp_q.size(), 0);
      check("rnd_triggers", n_starts - s0, (l - f + 1) << av);
      check("rnd_settle_runs", settle_runs.size(), l - f + 1);
      foreach (settle_runs[i]) check("rnd_settle_len", settle_runs[i], st + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
